// File: rtl/dbg_uart_loader_if.sv
// Byte-stream and debug-memory-port signals of the UART debug loader.
// master: the loader. slave: the UART engines and SoC debug port that it talks to.
interface dbg_uart_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [31:0] dbg_di;

  modport master (
    input  rx_data, rx_valid, tx_busy, dbg_di,
    output tx_data, tx_start, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, dbg_di,
    input  tx_data, tx_start, dbg_mem_op, dbg_wren, dbg_adr, dbg_do
  );
endinterface

// File: rtl/dbg_uart_loader.sv
// UART command parser that masters the SoC debug memory port and controls CPU reset.
// Define DBG_LOADER_TIMEOUT_EN to abort a stalled frame after TIMEOUT idle cycles in ARGS.
module dbg_uart_loader #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic               clk,
  input  logic               n_reset,
  output logic               cpu_n_reset,
  dbg_uart_loader_if.master  bus
);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [1:0] {IDLE, ARGS, MEM, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] do_q, do_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  left_q, left_d;
  logic [15:0] mem_cnt_q, mem_cnt_d;
  logic        cpu_q, cpu_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        guard_q, guard_d;
`ifdef DBG_LOADER_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    adr_d      = adr_q;
    do_d       = do_q;
    resp_d     = resp_q;
    left_d     = left_q;
    mem_cnt_d  = mem_cnt_q;
    cpu_d      = cpu_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    // The transmitter may not raise busy until a cycle after it sees tx_start.
    guard_d    = tx_start_q;
`ifdef DBG_LOADER_TIMEOUT_EN
    idle_d     = 32'd0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (bus.rx_valid) begin
          left_d = 3'd1;
          state_d = RESP;
          case (bus.rx_data)
            8'h57: begin rd_d = 1'b0; state_d = ARGS; end
            8'h52: begin rd_d = 1'b1; state_d = ARGS; end
            8'h48: begin cpu_d = 1'b0; resp_d = {24'h0, ACK}; end
            8'h47: begin cpu_d = 1'b1; resp_d = {24'h0, ACK}; end
            default: resp_d = {24'h0, NAK};
          endcase
        end
      end
      ARGS: begin
        if (bus.rx_valid) begin
          if (cnt_q[2]) do_d[8*cnt_q[1:0] +: 8] = bus.rx_data;
          else          adr_d[8*cnt_q[1:0] +: 8] = bus.rx_data;
          cnt_d = cnt_q + 3'd1;
          if ((rd_q && cnt_q == 3'd3) || cnt_q == 3'd7) begin
            cnt_d     = 3'd0;
            mem_cnt_d = 16'd0;
            state_d   = MEM;
          end
        end
`ifdef DBG_LOADER_TIMEOUT_EN
        else begin
          idle_d = idle_q + 32'd1;
          if (idle_d >= 32'(TIMEOUT)) begin
            idle_d  = 32'd0;
            cnt_d   = 3'd0;
            state_d = IDLE;
          end
        end
`endif
      end
      MEM: begin
        mem_cnt_d = mem_cnt_q + 16'd1;
        if (mem_cnt_q == 16'(MEM_WAIT - 1)) begin
          state_d = RESP;
          if (rd_q) begin
            resp_d = bus.dbg_di;
            left_d = 3'd4;
          end else begin
            resp_d = {24'h0, ACK};
            left_d = 3'd1;
          end
        end
      end
      RESP: begin
        if (!tx_start_q && !guard_q) begin
          if (left_q == 3'd0) begin
            state_d = IDLE;
          end else if (!bus.tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = resp_q[7:0];
            resp_d     = resp_q >> 8;
            left_d     = left_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      rd_q       <= 1'b0;
      adr_q      <= 32'd0;
      do_q       <= 32'd0;
      resp_q     <= 32'd0;
      left_q     <= 3'd0;
      mem_cnt_q  <= 16'd0;
      cpu_q      <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      guard_q    <= 1'b0;
`ifdef DBG_LOADER_TIMEOUT_EN
      idle_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      adr_q      <= adr_d;
      do_q       <= do_d;
      resp_q     <= resp_d;
      left_q     <= left_d;
      mem_cnt_q  <= mem_cnt_d;
      cpu_q      <= cpu_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      guard_q    <= guard_d;
`ifdef DBG_LOADER_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign bus.dbg_mem_op = (state_q == MEM);
  assign bus.dbg_wren   = (state_q == MEM && !rd_q) ? 4'hF : 4'h0;
  assign bus.dbg_adr    = adr_q;
  assign bus.dbg_do     = do_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign cpu_n_reset    = cpu_q;
endmodule

// File: tb/tb_dbg_uart_loader.sv
// Bench for dbg_uart_loader: table of command frames plus hand-written reset/drop/timeout
// sequences, with reply and memory-op scoreboards fed from the stimulus side.
module tb_dbg_uart_loader;
  localparam int MEM_WAIT = 2;
  localparam int TB_BUSY  = 20;

  typedef struct {
    logic [71:0] bytes;
    int          n;
    logic [31:0] rep;
    int          nr;
    bit          mem;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  wren;
    logic        cpu;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  wren;
  } mexp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic cpu_n_reset;
  dbg_uart_loader_if bus();

  dbg_uart_loader #(.MEM_WAIT(MEM_WAIT), .TIMEOUT(50)) dut (
    .clk(clk), .n_reset(n_reset), .cpu_n_reset(cpu_n_reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  mexp_t       expm[$];
  logic [31:0] mem [logic [31:0]];
  int          busy_cnt = 0;
  int          win_len = 0;
  bit          unstable = 0;
  logic [31:0] w_adr, w_do;
  logic [3:0]  w_wren;
  vec_t        vecs [12];

  function automatic logic [31:0] rdmem(logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic vec_t mk_w(logic [31:0] a, logic [31:0] d, logic cpu);
    vec_t v;
    v.bytes = {d, a, 8'h57}; v.n = 9; v.rep = 32'h06; v.nr = 1;
    v.mem = 1; v.adr = a; v.dat = d; v.wren = 4'hF; v.cpu = cpu;
    return v;
  endfunction

  function automatic vec_t mk_r(logic [31:0] a, logic [31:0] d, logic cpu);
    vec_t v;
    v.bytes = {32'h0, a, 8'h52}; v.n = 5; v.rep = d; v.nr = 4;
    v.mem = 1; v.adr = a; v.dat = 32'h0; v.wren = 4'h0; v.cpu = cpu;
    return v;
  endfunction

  function automatic vec_t mk_c(logic [7:0] c, logic [7:0] r, logic cpu);
    vec_t v;
    v.bytes = {64'h0, c}; v.n = 1; v.rep = {24'h0, r}; v.nr = 1;
    v.mem = 0; v.adr = 32'h0; v.dat = 32'h0; v.wren = 4'h0; v.cpu = cpu;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || expm.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || expm.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending replies %0d mem ops %0d expected 0", exp_q.size(), expm.size());
      exp_q.delete();
      expm.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic push_exp(vec_t v);
    for (int i = 0; i < v.nr; i++) exp_q.push_back(v.rep[8*i +: 8]);
    if (v.mem) expm.push_back('{adr: v.adr, dat: v.dat, wren: v.wren});
  endtask

  task automatic run_vec(int idx, vec_t v);
    push_exp(v);
    for (int i = 0; i < v.n; i++) send_byte(v.bytes[8*i +: 8]);
    drain();
    chk($sformatf("vec%0d cpu_n_reset", idx), {31'h0, cpu_n_reset}, {31'h0, v.cpu});
    chk($sformatf("vec%0d mem_op idle", idx), {31'h0, bus.dbg_mem_op}, 32'h0);
  endtask

  // Memory model writes on the clock edge; read data presented while the bus owns memory.
  always @(posedge clk)
    if (n_reset && bus.dbg_mem_op && bus.dbg_wren == 4'hF) mem[bus.dbg_adr] = bus.dbg_do;

  // Transmitter model plus reply and memory-window monitors.
  always @(negedge clk) begin
    bus.dbg_di = bus.dbg_mem_op ? rdmem(bus.dbg_adr) : 32'h0;
    if (bus.tx_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL reply: unexpected byte %h", bus.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL reply: got %h expected %h", bus.tx_data, e);
        end
      end
      busy_cnt = TB_BUSY;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = (busy_cnt != 0);
    if (!n_reset) begin
      win_len = 0;
      unstable = 0;
    end else if (bus.dbg_mem_op) begin
      if (win_len == 0) begin
        w_adr = bus.dbg_adr; w_do = bus.dbg_do; w_wren = bus.dbg_wren;
      end else if (bus.dbg_adr !== w_adr || bus.dbg_do !== w_do || bus.dbg_wren !== w_wren) begin
        unstable = 1;
      end
      win_len++;
    end else if (win_len != 0) begin
      checks++;
      if (expm.size() == 0) begin
        errors++;
        $display("FAIL memop: unexpected op adr %h wren %h", w_adr, w_wren);
      end else begin
        mexp_t m;
        m = expm.pop_front();
        if (win_len != MEM_WAIT || unstable || w_adr !== m.adr || w_wren !== m.wren ||
            (m.wren != 4'h0 && w_do !== m.dat)) begin
          errors++;
          $display("FAIL memop: got len %0d unstable %0d adr %h do %h wren %h expected len %0d adr %h do %h wren %h",
                   win_len, unstable, w_adr, w_do, w_wren, MEM_WAIT, m.adr, m.dat, m.wren);
        end
      end
      win_len = 0;
      unstable = 0;
    end
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    bus.dbg_di   = 32'h0;
    mem[32'h20004] = 32'h11223344;
    mem[32'h00000003] = 32'hA5A55A5A;

    vecs[0]  = mk_w(32'h00020000, 32'h0000006F, 1'b0);
    vecs[1]  = mk_r(32'h00020004, 32'h11223344, 1'b0);
    vecs[2]  = mk_c(8'h47, 8'h06, 1'b1);
    vecs[3]  = mk_c(8'h48, 8'h06, 1'b0);
    vecs[4]  = mk_c(8'hAA, 8'h15, 1'b0);
    vecs[5]  = mk_w(32'h00020008, 32'hDEADBEEF, 1'b0);
    vecs[6]  = mk_r(32'h00020008, 32'hDEADBEEF, 1'b0);
    vecs[7]  = mk_r(32'h00020000, 32'h0000006F, 1'b0);
    vecs[8]  = mk_r(32'h00000003, 32'hA5A55A5A, 1'b0);
    vecs[9]  = mk_c(8'h47, 8'h06, 1'b1);
    vecs[10] = mk_w(32'hFFFFFFFC, 32'h12345678, 1'b1);
    vecs[11] = mk_r(32'hFFFFFFFC, 32'h12345678, 1'b1);

    // Reset values, then held for ten cycles after release.
    repeat (3) @(negedge clk);
    chk("rst cpu_n_reset", {31'h0, cpu_n_reset}, 32'h0);
    chk("rst mem_op", {31'h0, bus.dbg_mem_op}, 32'h0);
    chk("rst tx_start", {31'h0, bus.tx_start}, 32'h0);
    chk("rst wren", {28'h0, bus.dbg_wren}, 32'h0);
    chk("rst adr", bus.dbg_adr, 32'h0);
    chk("rst do", bus.dbg_do, 32'h0);
    chk("rst tx_data", {24'h0, bus.tx_data}, 32'h0);
    n_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post-rst outputs", {29'h0, cpu_n_reset, bus.dbg_mem_op, bus.tx_start}, 32'h0);
    end

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // A command byte arriving while a reply is being sent is dropped.
    push_exp(mk_r(32'h00020004, 32'h11223344, 1'b1));
    begin
      vec_t v;
      int k;
      v = mk_r(32'h00020004, 32'h11223344, 1'b1);
      for (int i = 0; i < v.n; i++) send_byte(v.bytes[8*i +: 8]);
      k = 0;
      while (exp_q.size() > 3 && k < 2000) begin @(negedge clk); k++; end
      chk("drop: first byte sent", {31'h0, exp_q.size() <= 3}, 32'h1);
      send_byte(8'h48);
      drain();
      chk("drop: cpu_n_reset", {31'h0, cpu_n_reset}, 32'h1);
    end

    // Reset mid-frame discards the partial frame and holds the CPU.
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    chk("midrst cpu_n_reset", {31'h0, cpu_n_reset}, 32'h0);
    chk("midrst adr", bus.dbg_adr, 32'h0);
    n_reset = 1'b1;
    run_vec(100, mk_r(32'h00000000, 32'h00000000, 1'b0));

`ifdef DBG_LOADER_TIMEOUT_EN
    // Stalled frame times out silently; the next command parses from scratch.
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (60) @(negedge clk);
    run_vec(200, mk_c(8'h47, 8'h06, 1'b1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
